// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Brief    : Round-robin arbiter sharing one register-file write-back port
//             between the ALU result path (req 0) and the load path (req 1).
//             Optional macro WB_ARB_RANGE_CHECK_EN adds the err_range output.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DEPTH      = 15,
    parameter int LENGT      = 32,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_dest,
    input  logic [LENGT-1:0]  req0_value,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_dest,
    input  logic [LENGT-1:0]  req1_value,
    output logic              req1_ready,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [LENGT-1:0]  wb_value,
    output logic              busy
`ifdef WB_ARB_RANGE_CHECK_EN
    ,
    output logic              err_range
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0]        w_in_valid;
    logic [ADDR_W-1:0] w_in_dest  [2];
    logic [LENGT-1:0]  w_in_value [2];
    logic [1:0]        w_ready;
    logic [1:0]        w_not_empty;
    logic [1:0]        w_grant;
    logic [ADDR_W-1:0] w_head_dest  [2];
    logic [LENGT-1:0]  w_head_value [2];

    assign w_in_valid    = {req1_valid, req0_valid};
    assign w_in_dest[0]  = req0_dest;
    assign w_in_dest[1]  = req1_dest;
    assign w_in_value[0] = req0_value;
    assign w_in_value[1] = req1_value;
    assign req0_ready    = w_ready[0];
    assign req1_ready    = w_ready[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [PTR_W-1:0]  wr_ptr_q;
        logic [PTR_W-1:0]  rd_ptr_q;
        logic [CNT_W-1:0]  count_q;
        logic [ADDR_W-1:0] dest_mem_q  [FIFO_DEPTH];
        logic [LENGT-1:0]  value_mem_q [FIFO_DEPTH];
        logic              w_push;
        logic              w_pop;

        // Ready looks only at the registered count, never at a same-cycle pop.
        assign w_ready[gi]      = !rst && (count_q < CNT_W'(FIFO_DEPTH));
        assign w_not_empty[gi]  = (count_q != '0);
        assign w_push           = w_in_valid[gi] & w_ready[gi];
        assign w_pop            = w_grant[gi];
        assign w_head_dest[gi]  = dest_mem_q[rd_ptr_q];
        assign w_head_value[gi] = value_mem_q[rd_ptr_q];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) begin
                dest_mem_q[wr_ptr_q]  <= w_in_dest[gi];
                value_mem_q[wr_ptr_q] <= w_in_value[gi];
            end
        end
    end

    logic              rr_q;
    logic              rr_d;
    logic              wb_en_q;
    logic [ADDR_W-1:0] wb_dest_q;
    logic [LENGT-1:0]  wb_value_q;
    logic              err_q;
    logic              w_grant_any;
    logic              w_bad_dest;
    logic              w_write;
    logic [ADDR_W-1:0] w_sel_dest;
    logic [LENGT-1:0]  w_sel_value;

    always_comb begin
        w_grant    = 2'b00;
        rr_d       = rr_q;
        w_grant[0] = w_not_empty[0] && (!w_not_empty[1] || !rr_q);
        w_grant[1] = w_not_empty[1] && (!w_not_empty[0] ||  rr_q);
        if (w_grant[0])      rr_d = 1'b1;
        else if (w_grant[1]) rr_d = 1'b0;
    end

    assign w_grant_any = |w_grant;
    assign w_sel_dest  = w_grant[1] ? w_head_dest[1]  : w_head_dest[0];
    assign w_sel_value = w_grant[1] ? w_head_value[1] : w_head_value[0];

`ifdef WB_ARB_RANGE_CHECK_EN
    // Out-of-range entries still burn their slot and advance the RR pointer.
    assign w_bad_dest = w_grant_any && (32'(w_sel_dest) >= DEPTH);
    assign err_range  = err_q;
`else
    assign w_bad_dest = 1'b0;
`endif
    assign w_write = w_grant_any & ~w_bad_dest;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q       <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_dest_q  <= '0;
            wb_value_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            wb_en_q <= w_write;
            err_q   <= w_bad_dest;
            if (w_write) begin
                wb_dest_q  <= w_sel_dest;
                wb_value_q <= w_sel_value;
            end
        end
    end

    assign wb_en    = wb_en_q;
    assign wb_dest  = wb_dest_q;
    assign wb_value = wb_value_q;
    assign busy     = w_not_empty[0] | w_not_empty[1] | wb_en_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Brief    : Scoreboard bench for wb_port_arbiter; directed write sequences
//             with hand-ordered expected write-back streams.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_dest, req1_dest;
    logic [31:0] req0_value, req1_value;
    logic        req0_ready, req1_ready;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        busy;
`ifdef WB_ARB_RANGE_CHECK_EN
    logic        err_range;
`endif

    wb_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_dest  (req0_dest),
        .req0_value (req0_value),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_dest  (req1_dest),
        .req1_value (req1_value),
        .req1_ready (req1_ready),
        .wb_en      (wb_en),
        .wb_dest    (wb_dest),
        .wb_value   (wb_value),
        .busy       (busy)
`ifdef WB_ARB_RANGE_CHECK_EN
        ,
        .err_range  (err_range)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] exp_q[$];
    logic [31:0] regfile [16];
    bit          bp_mon = 1'b0;
    bit          saw_bp1 = 1'b0;

    // Scoreboard monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        logic [35:0] e;
        if (!rst && wb_en) begin
            regfile[wb_dest] = wb_value;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got dest=%0d value=%h, required no write", wb_dest, wb_value);
            end else begin
                e = exp_q.pop_front();
                if ({wb_dest, wb_value} !== e) begin
                    errors++;
                    $display("FAIL wb_write: got dest=%0d value=%h, required dest=%0d value=%h",
                             wb_dest, wb_value, e[35:32], e[31:0]);
                end
            end
        end
        if (bp_mon && req1_valid && !req1_ready) saw_bp1 = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [3:0] d, input logic [31:0] v);
        bit ok = 1'b0;
        req0_valid = 1'b1; req0_dest = d; req0_value = v;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk); ok = req0_ready;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        if (!ok) chk("push0_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_b(input logic [3:0] d, input logic [31:0] v);
        bit ok = 1'b0;
        req1_valid = 1'b1; req1_dest = d; req1_value = v;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk); ok = req1_ready;
            @(posedge clk); #1;
        end
        req1_valid = 1'b0;
        if (!ok) chk("push1_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(posedge clk); #1;
            done = !busy && (exp_q.size() == 0);
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_dest = '0; req0_value = '0;
        req1_valid = 1'b0; req1_dest = '0; req1_value = '0;
        foreach (regfile[i]) regfile[i] = '0;
        repeat (2) @(posedge clk); #1;
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_dest", 32'(wb_dest), 32'd0);
        chk("rst_wb_value", wb_value, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready0", 32'(req0_ready), 32'd1);
        chk("post_rst_ready1", 32'(req1_ready), 32'd1);

        // Single write: accept at edge N, strobe after edge N+1 for one cycle.
        exp_q.push_back({4'd3, 32'hDEADBEEF});
        push_a(4'd3, 32'hDEADBEEF);
        chk("single_no_bypass", 32'(wb_en), 32'd0);
        @(posedge clk); #1;
        chk("single_wb_en", 32'(wb_en), 32'd1);
        chk("single_wb_dest", 32'(wb_dest), 32'd3);
        @(posedge clk); #1;
        chk("single_wb_en_drop", 32'(wb_en), 32'd0);
        chk("single_busy_drop", 32'(busy), 32'd0);
        wait_idle();

        // Round-robin from rr=0: r1, r5, r2, r6 back to back.
        reset_pulse();
        exp_q.push_back({4'd1, 32'h0000_0101});
        exp_q.push_back({4'd5, 32'h0000_0505});
        exp_q.push_back({4'd2, 32'h0000_0202});
        exp_q.push_back({4'd6, 32'h0000_0606});
        fork
            push_a(4'd1, 32'h0000_0101);
            push_b(4'd5, 32'h0000_0505);
        join
        fork
            push_a(4'd2, 32'h0000_0202);
            push_b(4'd6, 32'h0000_0606);
        join
        for (int k = 0; k < 4; k++) begin
            chk("rr_wb_en_run", 32'(wb_en), 32'd1);
            @(posedge clk); #1;
        end
        chk("rr_wb_en_end", 32'(wb_en), 32'd0);
        wait_idle();

        // Collision on r7 with rr=1: 0x22 first, 0x11 last wins.
        exp_q.push_back({4'd4, 32'h0000_0044});
        push_a(4'd4, 32'h0000_0044);
        wait_idle();
        exp_q.push_back({4'd7, 32'h0000_0022});
        exp_q.push_back({4'd7, 32'h0000_0011});
        fork
            push_a(4'd7, 32'h0000_0011);
            push_b(4'd7, 32'h0000_0022);
        join
        wait_idle();
        chk("collision_r7", regfile[7], 32'h0000_0011);

        // dest=15 from req0 with rr=0, then a dual push shows rr moved to 1.
        exp_q.push_back({4'd6, 32'h0000_0066});
        push_b(4'd6, 32'h0000_0066);
        wait_idle();
`ifdef WB_ARB_RANGE_CHECK_EN
        push_a(4'd15, 32'h0000_0005);
        @(posedge clk); #1;
        chk("range_err_pulse", 32'(err_range), 32'd1);
        chk("range_wb_en_low", 32'(wb_en), 32'd0);
        @(posedge clk); #1;
        chk("range_err_drop", 32'(err_range), 32'd0);
`else
        exp_q.push_back({4'd15, 32'h0000_0005});
        push_a(4'd15, 32'h0000_0005);
        @(posedge clk); #1;
        chk("range_wb_en", 32'(wb_en), 32'd1);
        chk("range_wb_dest", 32'(wb_dest), 32'd15);
`endif
        exp_q.push_back({4'd10, 32'h0000_0B10});
        exp_q.push_back({4'd9,  32'h0000_0A09});
        fork
            push_a(4'd9,  32'h0000_0A09);
            push_b(4'd10, 32'h0000_0B10);
        join
        wait_idle();

        // Backpressure: both producers saturated from rr=0 alternate a,b,a,b...
        reset_pulse();
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({4'(k),     32'hA000_0000 + 32'(k)});
            exp_q.push_back({4'(k + 8), 32'hB000_0000 + 32'(k)});
        end
        bp_mon = 1'b1;
        fork
            for (int k = 0; k < 5; k++) push_a(4'(k), 32'hA000_0000 + 32'(k));
            for (int j = 0; j < 5; j++) push_b(4'(j + 8), 32'hB000_0000 + 32'(j));
        join
        wait_idle();
        bp_mon = 1'b0;
        chk("bp_ready1_dropped", 32'(saw_bp1), 32'd1);

        // Mid-stream reset with two entries queued in FIFO 0 and one in flight.
        exp_q.push_back({4'd11, 32'h0000_0001});
        push_a(4'd11, 32'h0000_0001);
        wait_idle();
        fork
            push_a(4'd12, 32'h0000_0C0C);
            push_b(4'd13, 32'h0000_0D0D);
        join
        fork
            push_a(4'd14, 32'h0000_0E0E);
            push_b(4'd1,  32'h0000_0F0F);
        join
        rst = 1'b1;
        #1;
        chk("midrst_wb_en", 32'(wb_en), 32'd0);
        chk("midrst_wb_dest", 32'(wb_dest), 32'd0);
        chk("midrst_wb_value", wb_value, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready0", 32'(req0_ready), 32'd0);
        chk("midrst_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_rel_ready0", 32'(req0_ready), 32'd1);
        chk("midrst_rel_busy", 32'(busy), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
